core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive MEM grants while IF waits; used only with fairness enabled.
REQ-002 SHALL have ports: i_clk in 1, system clock; i_reset in 1, reset (synchronous, active-high; clock i_clk).
REQ-003 SHALL have IF requester ports: i_if_req in 1, fetch request (level); i_if_addr in 64, fetch address; o_if_ack out 1, completion pulse; o_if_rdata out 64, fetch data; o_if_err out 1, bus error with ack.
REQ-004 SHALL have MEM requester ports: i_mem_req in 1, i_mem_we in 1, i_mem_addr in 64, i_mem_wdata in 64, i_mem_be in 8, o_mem_ack out 1, o_mem_rdata out 64, o_mem_err out 1 (same meanings as IF, plus write enable, write data and byte enables).
REQ-005 SHALL have bus ports: o_bus_req out 1, o_bus_we out 1, o_bus_addr out 64, o_bus_wdata out 64, o_bus_be out 8, i_bus_ack in 1, i_bus_rdata in 64, i_bus_err in 1.
REQ-006 SHALL have i_flush in 1, pipeline flush (cancels fetch only), and o_busy out 1, high in any state other than IDLE.

Function
REQ-007 SHALL implement states IDLE, GRANT_IF, GRANT_MEM, DRAIN.
REQ-008 In IDLE with o_if_ack and o_mem_ack both low: MEM request only -> GRANT_MEM; IF request only and i_flush low -> GRANT_IF; both pending -> winner per REQ-016/017.
REQ-009 Requests SHALL be held high until ack; the arbiter SHALL NOT arbitrate in a cycle where o_if_ack or o_mem_ack is high, so a stale request is never regranted.
REQ-010 On grant, the winner's address, we (0 for IF), wdata and be (8'hFF for IF) SHALL be registered onto the bus outputs, and o_bus_req SHALL go high in the cycle after the grant decision.
REQ-011 Bus outputs SHALL remain stable while o_bus_req is high; o_bus_req SHALL deassert in the cycle after i_bus_ack is sampled.
REQ-012 On i_bus_ack in GRANT_x: o_x_ack SHALL pulse exactly one cycle later, o_x_rdata SHALL hold i_bus_rdata captured at ack, o_x_err SHALL equal i_bus_err captured at ack, and the state SHALL return to IDLE.
REQ-013 Minimum latency: request in cycle 0 -> o_bus_req in cycle 1; i_bus_ack in cycle k -> o_x_ack in cycle k+1; next o_bus_req no earlier than cycle k+3.
REQ-014 i_flush in GRANT_IF SHALL go to DRAIN; DRAIN SHALL keep o_bus_req high until i_bus_ack, then return to IDLE with no o_if_ack and no o_if_err.
REQ-015 i_flush SHALL NOT affect GRANT_MEM or a MEM grant made in the same cycle; i_flush in DRAIN SHALL have no further effect.
REQ-016 Without fairness: simultaneous requests SHALL always grant MEM.
REQ-017 With fairness: a 3-bit starvation counter SHALL increment on each MEM grant made while i_if_req is high; when the counter equals STARVE_LIMIT, a simultaneous request SHALL grant IF; any IF grant SHALL clear the counter; the counter SHALL saturate at STARVE_LIMIT.
REQ-018 i_bus_ack in IDLE SHALL be ignored.

Reset
REQ-019 On i_reset: state IDLE; o_bus_req, o_bus_we, o_if_ack, o_mem_ack, o_if_err, o_mem_err, o_busy all 0; o_bus_addr, o_bus_wdata, o_if_rdata and o_mem_rdata all 64'h0; o_bus_be 8'h0; starvation counter 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction immediately, with no ack to either requester; i_reset SHALL have priority over i_flush.

Configuration
REQ-021 Macro WIV_MEM_ARB_FAIR_EN: when defined, the starvation counter and REQ-017 SHALL be compiled in; when undefined, there SHALL be no counter, STARVE_LIMIT SHALL be unused, and REQ-016 applies.

Verification
REQ-022 IF only, addr 64'h1000, bus acks after 2 cycles with 64'hDEADBEEF -> o_bus_req in cycle 1, o_bus_be 8'hFF, o_if_ack one cycle after i_bus_ack, o_if_rdata 64'hDEADBEEF.
REQ-023 Simultaneous IF and MEM store (addr 64'h2000, wdata 64'h55, be 8'h0F) -> MEM served first with o_bus_we 1 and be 8'h0F, then IF served; no overlapping o_bus_req.
REQ-024 i_flush one cycle after IF grant, bus acks 3 cycles later -> DRAIN, o_bus_req held until ack, no o_if_ack; a pending MEM request is granted after return to IDLE.
REQ-025 With WIV_MEM_ARB_FAIR_EN and STARVE_LIMIT 4, both requests continuously asserted -> MEM,MEM,MEM,MEM,IF grant order, then the counter restarts; without the macro -> MEM only.
REQ-026 i_bus_ack with i_bus_err 1 on a MEM load -> o_mem_ack and o_mem_err both pulse; i_reset during GRANT_MEM -> all outputs at reset values next cycle, no ack.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// ----------------------------------------------------------------------------
// core_mem_arbiter
//
// Purpose:
//   Two-requester arbiter that shares a single memory bus between an
//   instruction-fetch port (IF) and a load/store port (MEM). One transaction
//   is outstanding on the bus at a time. A pipeline flush cancels an
//   in-flight fetch: the bus cycle is drained silently with no ack to IF.
//
// Configuration macro:
//   WIV_MEM_ARB_FAIR_EN - when defined, a 3-bit starvation counter lets IF
//                         win a tie after STARVE_LIMIT consecutive MEM grants
//                         made while IF was waiting. When undefined, MEM
//                         always wins a tie and STARVE_LIMIT has no effect.
//
// Parameters:
//   STARVE_LIMIT   consecutive MEM grants tolerated while IF waits (1..7)
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_if_req, i_if_addr      fetch request (level, held until ack) + address
//   o_if_ack/rdata/err       fetch completion pulse, data, bus error
//   i_mem_req/we/addr/wdata/be  load/store request (held until ack)
//   o_mem_ack/rdata/err      load/store completion pulse, data, bus error
//   o_bus_req/we/addr/wdata/be  registered bus request, stable while req high
//   i_bus_ack/rdata/err      bus completion, read data, error
//   i_flush                  cancels an in-flight fetch only
//   o_busy                   high whenever the arbiter is not IDLE
// ----------------------------------------------------------------------------
module core_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_if_req,
    input  logic [63:0] i_if_addr,
    output logic        o_if_ack,
    output logic [63:0] o_if_rdata,
    output logic        o_if_err,

    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [63:0] i_mem_addr,
    input  logic [63:0] i_mem_wdata,
    input  logic [7:0]  i_mem_be,
    output logic        o_mem_ack,
    output logic [63:0] o_mem_rdata,
    output logic        o_mem_err,

    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [63:0] o_bus_addr,
    output logic [63:0] o_bus_wdata,
    output logic [7:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [63:0] i_bus_rdata,
    input  logic        i_bus_err,

    input  logic        i_flush,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IF,
        GRANT_MEM,
        DRAIN
    } state_t;

    state_t state;

    // The counter is three bits wide, so the limit must fit in it.
    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
            $error("core_mem_arbiter: STARVE_LIMIT must be in 1..7");
        end
    endgenerate

    // While an ack is being presented the requester has not yet had a chance
    // to drop its request, so arbitrating now would regrant a stale request.
    logic ack_pending;
    logic if_eligible;
    logic pick_if;
    logic pick_mem;

    assign ack_pending = o_if_ack | o_mem_ack;
    assign if_eligible = i_if_req & ~i_flush;

`ifdef WIV_MEM_ARB_FAIR_EN
    logic [2:0] starve_cnt;
    logic       starved;

    assign starved  = (starve_cnt == 3'(STARVE_LIMIT));
    // IF wins a tie only once MEM has been favoured STARVE_LIMIT times.
    assign pick_if  = if_eligible & (~i_mem_req | starved);
`else
    assign pick_if  = if_eligible & ~i_mem_req;
`endif
    assign pick_mem = i_mem_req & ~pick_if;

    // Single state machine; every output is registered here. Ack and error
    // outputs default low each cycle so they form one-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 64'h0;
            o_bus_wdata <= 64'h0;
            o_bus_be    <= 8'h0;
            o_if_ack    <= 1'b0;
            o_if_rdata  <= 64'h0;
            o_if_err    <= 1'b0;
            o_mem_ack   <= 1'b0;
            o_mem_rdata <= 64'h0;
            o_mem_err   <= 1'b0;
            o_busy      <= 1'b0;
`ifdef WIV_MEM_ARB_FAIR_EN
            starve_cnt  <= 3'd0;
`endif
        end else begin
            o_if_ack  <= 1'b0;
            o_if_err  <= 1'b0;
            o_mem_ack <= 1'b0;
            o_mem_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!ack_pending) begin
                        if (pick_if) begin
                            state       <= GRANT_IF;
                            o_busy      <= 1'b1;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= 1'b0;
                            o_bus_addr  <= i_if_addr;
                            o_bus_wdata <= 64'h0;
                            o_bus_be    <= 8'hFF;
`ifdef WIV_MEM_ARB_FAIR_EN
                            starve_cnt  <= 3'd0;
`endif
                        end else if (pick_mem) begin
                            state       <= GRANT_MEM;
                            o_busy      <= 1'b1;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= i_mem_we;
                            o_bus_addr  <= i_mem_addr;
                            o_bus_wdata <= i_mem_wdata;
                            o_bus_be    <= i_mem_be;
`ifdef WIV_MEM_ARB_FAIR_EN
                            // Only grants that make IF wait count, saturating.
                            if (i_if_req && !starved) begin
                                starve_cnt <= starve_cnt + 3'd1;
                            end
`endif
                        end
                    end
                end

                GRANT_IF: begin
                    if (i_bus_ack) begin
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_bus_req <= 1'b0;
                        // A flush arriving with the ack still cancels the fetch.
                        if (!i_flush) begin
                            o_if_ack   <= 1'b1;
                            o_if_rdata <= i_bus_rdata;
                            o_if_err   <= i_bus_err;
                        end
                    end else if (i_flush) begin
                        state <= DRAIN;
                    end
                end

                GRANT_MEM: begin
                    if (i_bus_ack) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_bus_req   <= 1'b0;
                        o_mem_ack   <= 1'b1;
                        o_mem_rdata <= i_bus_rdata;
                        o_mem_err   <= i_bus_err;
                    end
                end

                DRAIN: begin
                    // The bus cycle cannot be aborted, so wait it out silently.
                    if (i_bus_ack) begin
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_bus_req <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    o_busy    <= 1'b0;
                    o_bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_core_mem_arbiter
//
// Purpose:
//   Directed self-checking bench for core_mem_arbiter. The bus is modelled by
//   hand-driven ack/data; all expected values are written into the steps.
//   Honours WIV_MEM_ARB_FAIR_EN for the expected grant order under contention.
// ----------------------------------------------------------------------------
module tb_core_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_be;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err;
    logic        flush;
    logic        busy;

    int checks = 0;
    int errors = 0;

    core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (if_ack),
        .o_if_rdata  (if_rdata),
        .o_if_err    (if_err),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .i_mem_be    (mem_be),
        .o_mem_ack   (mem_ack),
        .o_mem_rdata (mem_rdata),
        .o_mem_err   (mem_err),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_be    (bus_be),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata),
        .i_bus_err   (bus_err),
        .i_flush     (flush),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [63:0] iaddr,
                                 input logic mreq, input logic mwe,
                                 input logic [63:0] maddr, input logic [63:0] mwdata,
                                 input logic [7:0] mbe);
        if_req    = ireq;
        if_addr   = iaddr;
        mem_req   = mreq;
        mem_we    = mwe;
        mem_addr  = maddr;
        mem_wdata = mwdata;
        mem_be    = mbe;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] exp_addr [6];
        int          n;

        reset = 1'b1;
        flush = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = 64'h0;
        bus_err = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        checkOutput("rst_bus_req", bus_req, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_bus_addr", bus_addr, 64'h0);
        checkOutput("rst_bus_be", bus_be, 8'h0);
        checkOutput("rst_if_ack", if_ack, 1'b0);
        checkOutput("rst_mem_rdata", mem_rdata, 64'h0);

        // Single fetch, bus acks two cycles after the request appears
        applyStimulus(1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
        tick();
        checkOutput("if_bus_req_c1", bus_req, 1'b1);
        checkOutput("if_bus_addr", bus_addr, 64'h1000);
        checkOutput("if_bus_be", bus_be, 8'hFF);
        checkOutput("if_bus_we", bus_we, 1'b0);
        checkOutput("if_busy", busy, 1'b1);
        tick();
        checkOutput("if_bus_req_c2", bus_req, 1'b1);
        checkOutput("if_no_early_ack", if_ack, 1'b0);
        tick();
        bus_ack = 1'b1;
        bus_rdata = 64'hDEADBEEF;
        tick();
        checkOutput("if_ack", if_ack, 1'b1);
        checkOutput("if_rdata", if_rdata, 64'hDEADBEEF);
        checkOutput("if_err", if_err, 1'b0);
        checkOutput("if_bus_req_drop", bus_req, 1'b0);
        bus_ack = 1'b0;
        if_req = 1'b0;
        tick();
        checkOutput("if_ack_pulse", if_ack, 1'b0);
        checkOutput("if_idle_busy", busy, 1'b0);

        // Bus ack in IDLE is ignored
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        checkOutput("idle_ack_if", if_ack, 1'b0);
        checkOutput("idle_ack_mem", mem_ack, 1'b0);
        checkOutput("idle_ack_bus_req", bus_req, 1'b0);

        // Simultaneous IF and MEM store: MEM first, then IF, no overlap
        applyStimulus(1'b1, 64'h3000, 1'b1, 1'b1, 64'h2000, 64'h55, 8'h0F);
        tick();
        checkOutput("tie_mem_addr", bus_addr, 64'h2000);
        checkOutput("tie_mem_we", bus_we, 1'b1);
        checkOutput("tie_mem_be", bus_be, 8'h0F);
        checkOutput("tie_mem_wdata", bus_wdata, 64'h55);
        bus_ack = 1'b1;
        bus_rdata = 64'h0;
        tick();
        checkOutput("tie_mem_ack", mem_ack, 1'b1);
        checkOutput("tie_if_not_acked", if_ack, 1'b0);
        checkOutput("tie_gap1", bus_req, 1'b0);
        bus_ack = 1'b0;
        mem_req = 1'b0;
        tick();
        checkOutput("tie_gap2", bus_req, 1'b0);
        tick();
        checkOutput("tie_if_bus_req", bus_req, 1'b1);
        checkOutput("tie_if_addr", bus_addr, 64'h3000);
        checkOutput("tie_if_we", bus_we, 1'b0);
        checkOutput("tie_if_be", bus_be, 8'hFF);
        bus_ack = 1'b1;
        bus_rdata = 64'h1234;
        tick();
        checkOutput("tie_if_ack", if_ack, 1'b1);
        checkOutput("tie_if_rdata", if_rdata, 64'h1234);
        bus_ack = 1'b0;
        if_req = 1'b0;
        tick();

        // Flush one cycle after an IF grant drains the fetch silently
        applyStimulus(1'b1, 64'h4000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
        tick();
        checkOutput("fl_grant", bus_req, 1'b1);
        flush = 1'b1;
        applyStimulus(1'b0, 64'h4000, 1'b1, 1'b0, 64'h5000, 64'h0, 8'hFF);
        tick();
        flush = 1'b0;
        checkOutput("fl_drain_req", bus_req, 1'b1);
        checkOutput("fl_drain_busy", busy, 1'b1);
        checkOutput("fl_drain_addr", bus_addr, 64'h4000);
        tick();
        checkOutput("fl_drain_req2", bus_req, 1'b1);
        checkOutput("fl_drain_no_ack", if_ack, 1'b0);
        bus_ack = 1'b1;
        bus_rdata = 64'h99;
        bus_err = 1'b1;
        tick();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        checkOutput("fl_done_req", bus_req, 1'b0);
        checkOutput("fl_no_if_ack", if_ack, 1'b0);
        checkOutput("fl_no_if_err", if_err, 1'b0);
        checkOutput("fl_if_rdata_kept", if_rdata, 64'h1234);
        checkOutput("fl_idle", busy, 1'b0);
        tick();
        checkOutput("fl_mem_grant", bus_req, 1'b1);
        checkOutput("fl_mem_addr", bus_addr, 64'h5000);

        // MEM load ending in a bus error
        bus_ack = 1'b1;
        bus_err = 1'b1;
        bus_rdata = 64'hAA;
        tick();
        checkOutput("err_mem_ack", mem_ack, 1'b1);
        checkOutput("err_mem_err", mem_err, 1'b1);
        checkOutput("err_mem_rdata", mem_rdata, 64'hAA);
        bus_ack = 1'b0;
        bus_err = 1'b0;
        mem_req = 1'b0;
        tick();
        checkOutput("err_ack_pulse", mem_ack, 1'b0);
        checkOutput("err_err_pulse", mem_err, 1'b0);

        // Reset during GRANT_MEM abandons the store, even with ack and flush
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h6000, 64'h77, 8'h03);
        tick();
        checkOutput("rm_grant", bus_req, 1'b1);
        reset = 1'b1;
        flush = 1'b1;
        bus_ack = 1'b1;
        tick();
        checkOutput("rm_bus_req", bus_req, 1'b0);
        checkOutput("rm_bus_addr", bus_addr, 64'h0);
        checkOutput("rm_bus_wdata", bus_wdata, 64'h0);
        checkOutput("rm_bus_be", bus_be, 8'h0);
        checkOutput("rm_bus_we", bus_we, 1'b0);
        checkOutput("rm_busy", busy, 1'b0);
        checkOutput("rm_no_mem_ack", mem_ack, 1'b0);
        reset = 1'b0;
        flush = 1'b0;
        bus_ack = 1'b0;
        mem_req = 1'b0;
        tick();
        checkOutput("rm_no_late_ack", mem_ack, 1'b0);

        // Both requesters held high continuously: grant order
`ifdef WIV_MEM_ARB_FAIR_EN
        exp_addr = '{64'hB000, 64'hB000, 64'hB000, 64'hB000, 64'hA000, 64'hB000};
`else
        exp_addr = '{64'hB000, 64'hB000, 64'hB000, 64'hB000, 64'hB000, 64'hB000};
`endif
        applyStimulus(1'b1, 64'hA000, 1'b1, 1'b0, 64'hB000, 64'h0, 8'hFF);
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (!bus_req && n < 8) begin
                tick();
                n++;
            end
            checkOutput($sformatf("order%0d_timeout", g), 64'(n < 8), 64'h1);
            checkOutput($sformatf("order%0d_addr", g), bus_addr, exp_addr[g]);
            bus_ack = 1'b1;
            bus_rdata = 64'(g);
            tick();
            bus_ack = 1'b0;
            if (exp_addr[g] == 64'hA000) begin
                checkOutput($sformatf("order%0d_if_ack", g), if_ack, 1'b1);
            end else begin
                checkOutput($sformatf("order%0d_mem_ack", g), mem_ack, 1'b1);
            end
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
        tick();
        tick();
        checkOutput("end_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
